// File: rtl/mem_stage_if.sv
// mem_stage_if: groups the MEM-stage pipeline buses.
//   flush           : clears the MEM pipeline register
//   stall           : stall vector (bit3 = MEM, bit4 = WB, 1 = stop)
//   ex_to_mem_bus   : payload from EX
//   data_sram_rdata : synchronous data-SRAM read data
//   mem_to_wb_bus   : payload to WB
//   mem_to_id_fwd   : {rf_we, rf_waddr, rf_wdata} bypass to ID
// The slave modport is the MEM stage; the master modport is its surroundings.
interface mem_stage_if #(
    parameter int EX_TO_MEM_WD = 81,
    parameter int MEM_TO_WB_WD = 70,
    parameter int STALL_WD     = 6
);
    logic                    flush;
    logic [STALL_WD-1:0]     stall;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic [31:0]             data_sram_rdata;
    logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
    logic [37:0]             mem_to_id_fwd;

    modport master (
        output flush, stall, ex_to_mem_bus, data_sram_rdata,
        input  mem_to_wb_bus, mem_to_id_fwd
    );

    modport slave (
        input  flush, stall, ex_to_mem_bus, data_sram_rdata,
        output mem_to_wb_bus, mem_to_id_fwd
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage MIPS pipeline.
// Registers the EX-to-MEM bus under stall/flush control, keeps the first-cycle
// SRAM read data of a stalled load, aligns/extends load data and drives the
// MEM-to-WB bus plus the ID forwarding bus.
// Ports:
//   clk : clock
//   rst : asynchronous active-high reset
//   io  : mem_stage_if.slave (flush, stall, ex_to_mem_bus, data_sram_rdata,
//         mem_to_wb_bus, mem_to_id_fwd)
module mem_stage #(
    parameter int EX_TO_MEM_WD = 81,
    parameter int MEM_TO_WB_WD = 70,
    parameter int STALL_WD     = 6
) (
    input  logic         clk,
    input  logic         rst,
    mem_stage_if.slave   io
);

    logic [EX_TO_MEM_WD-1:0] bus_reg;
    logic [EX_TO_MEM_WD-1:0] bus_next;
    logic                    bus_write;
    logic [31:0]             hold_data_reg;
    logic                    hold_valid_reg;

    // EX-to-MEM bus fields
    logic [4:0]  mem_op;
    logic [31:0] pc;
    logic        data_ram_en;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;

    assign mem_op      = bus_reg[80:76];
    assign pc          = bus_reg[75:44];
    assign data_ram_en = bus_reg[43];
    assign sel_rf_res  = bus_reg[38];
    assign rf_we       = bus_reg[37];
    assign rf_waddr    = bus_reg[36:32];
    assign ex_result   = bus_reg[31:0];

    // Store byte enables are consumed upstream; other stall bits belong to other stages.
    logic unused_bits;
    assign unused_bits = &{1'b0, bus_reg[42:39], io.stall[5], io.stall[2:0]};

    // Register is rewritten on flush, on a bubble (MEM stalled, WB running)
    // and on a normal advance; it only holds when MEM and WB are both stalled.
    assign bus_write = io.flush || !io.stall[3] || !io.stall[4];

    always_comb begin
        bus_next = bus_reg;
        if (io.flush || io.stall[3])
            bus_next = '0;
        else
            bus_next = io.ex_to_mem_bus;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_reg        <= '0;
            hold_data_reg  <= '0;
            hold_valid_reg <= 1'b0;
        end else if (bus_write) begin
            bus_reg        <= bus_next;
            hold_valid_reg <= 1'b0;
        end else if (data_ram_en && io.stall[3] && !hold_valid_reg) begin
            // SRAM data is only valid in the first occupancy cycle; freeze it.
            hold_data_reg  <= io.data_sram_rdata;
            hold_valid_reg <= 1'b1;
        end
    end

    logic [31:0] rdata_eff;
    assign rdata_eff = hold_valid_reg ? hold_data_reg : io.data_sram_rdata;

    // Little-endian byte lanes of the effective read word
    logic [7:0] rdata_byte [4];
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
            assign rdata_byte[gi] = rdata_eff[8*gi +: 8];
        end
    endgenerate

    logic [1:0]  addr_lo;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    assign addr_lo  = ex_result[1:0];
    assign sel_byte = rdata_byte[addr_lo];
    assign sel_half = addr_lo[1] ? rdata_eff[31:16] : rdata_eff[15:0];

    logic [31:0] load_result;
    always_comb begin
        load_result = '0;
        if (mem_op[4])
            load_result = {{24{sel_byte[7]}}, sel_byte};
        else if (mem_op[3])
            load_result = {24'b0, sel_byte};
        else if (mem_op[2])
            load_result = addr_lo[0] ? 32'b0 : {{16{sel_half[15]}}, sel_half};
        else if (mem_op[1])
            load_result = addr_lo[0] ? 32'b0 : {16'b0, sel_half};
        else if (mem_op[0])
            load_result = (addr_lo != 2'b00) ? 32'b0 : rdata_eff;
        else
            load_result = rdata_eff;
    end

    logic [31:0] rf_wdata;
    assign rf_wdata = sel_rf_res ? load_result : ex_result;

    assign io.mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata};
    assign io.mem_to_id_fwd = {rf_we, rf_waddr, rf_wdata};

endmodule
